// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter over a byte-wide memory read port; assembles little-endian words.
// Define FIXED_PRIORITY_EN to make I always win ties (default: round-robin).
module mem_port_arbiter #(
  parameter int BYTE_SIZE  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   I_REQ,
  input  logic [ADDR_WIDTH-1:0]  I_ADDR,
  output logic                   I_GNT,
  output logic                   I_VALID,
  output logic [BYTE_SIZE*8-1:0] I_RD,
  input  logic                   D_REQ,
  input  logic [ADDR_WIDTH-1:0]  D_ADDR,
  output logic                   D_GNT,
  output logic                   D_VALID,
  output logic [BYTE_SIZE*8-1:0] D_RD,
  output logic                   MEM_EN,
  output logic [ADDR_WIDTH-1:0]  MEM_ADDR,
  input  logic [7:0]             MEM_RD
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_owner_d;
  logic                  r_i_valid;
  logic                  r_d_valid;
  logic [BYTE_SIZE*8-1:0] r_i_rd;
  logic [BYTE_SIZE*8-1:0] r_d_rd;

  logic w_any_req;
  logic w_pick_d;
  logic w_last_lane;

  assign w_any_req   = I_REQ | D_REQ;
  assign w_last_lane = (r_cnt == 3'(BYTE_SIZE - 1));

`ifdef FIXED_PRIORITY_EN
  assign w_pick_d = D_REQ & ~I_REQ;
`else
  // Pointer remembers whether D was served last; reset as "D last".
  logic r_last_d;
  assign w_pick_d = D_REQ & (~I_REQ | ~r_last_d);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_last_d <= 1'b1;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last_d <= w_pick_d;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    I_GNT    = 1'b0;
    D_GNT    = 1'b0;
    MEM_EN   = 1'b0;
    MEM_ADDR = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          I_GNT  = ~w_pick_d;
          D_GNT  = w_pick_d;
          w_next = S_READ;
        end
      end
      S_READ: begin
        MEM_EN   = 1'b1;
        MEM_ADDR = r_base + ADDR_WIDTH'(r_cnt);
        if (w_last_lane) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt     <= '0;
      r_base    <= '0;
      r_owner_d <= 1'b0;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_i_rd    <= '0;
      r_d_rd    <= '0;
    end else begin
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_base    <= w_pick_d ? D_ADDR : I_ADDR;
            r_owner_d <= w_pick_d;
            r_cnt     <= '0;
          end
        end
        S_READ: begin
          // Lanes land directly in the owner's output register.
          for (int k = 0; k < BYTE_SIZE; k++) begin
            if (r_cnt == 3'(k)) begin
              if (r_owner_d) begin
                r_d_rd[8*k +: 8] <= MEM_RD;
              end else begin
                r_i_rd[8*k +: 8] <= MEM_RD;
              end
            end
          end
          r_cnt <= r_cnt + 3'd1;
          if (w_last_lane) begin
            r_i_valid <= ~r_owner_d;
            r_d_valid <= r_owner_d;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign I_VALID = r_i_valid;
  assign D_VALID = r_d_valid;
  assign I_RD    = r_i_rd;
  assign D_RD    = r_d_rd;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected bytes/words queued at grant,
// a negedge monitor pops and compares on MEM_EN and VALID.
module tb_mem_port_arbiter;

  localparam int BS = 4;
  localparam int AW = 32;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          I_REQ;
  logic [AW-1:0] I_ADDR;
  logic          I_GNT;
  logic          I_VALID;
  logic [BS*8-1:0] I_RD;
  logic          D_REQ;
  logic [AW-1:0] D_ADDR;
  logic          D_GNT;
  logic          D_VALID;
  logic [BS*8-1:0] D_RD;
  logic          MEM_EN;
  logic [AW-1:0] MEM_ADDR;
  logic [7:0]    MEM_RD;

  mem_port_arbiter #(.BYTE_SIZE(BS), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT),
    .I_VALID(I_VALID), .I_RD(I_RD),
    .D_REQ(D_REQ), .D_ADDR(D_ADDR), .D_GNT(D_GNT),
    .D_VALID(D_VALID), .D_RD(D_RD),
    .MEM_EN(MEM_EN), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [7:0] memf(input logic [31:0] a);
    case (a)
      32'h10:       return 8'hAA;
      32'h11:       return 8'hBB;
      32'h12:       return 8'hCC;
      32'h13:       return 8'hDD;
      32'h20:       return 8'h01;
      32'h21:       return 8'h02;
      32'h22:       return 8'h03;
      32'h23:       return 8'h04;
      32'h40:       return 8'h99;
      32'h41:       return 8'h88;
      32'h42:       return 8'h77;
      32'h43:       return 8'h66;
      32'hFFFFFFFE: return 8'h11;
      32'hFFFFFFFF: return 8'h22;
      32'h00000000: return 8'h33;
      32'h00000001: return 8'h44;
      default:      return 8'hEE;
    endcase
  endfunction

  assign MEM_RD = memf(MEM_ADDR);

  typedef struct {
    bit          d;
    logic [31:0] w;
    int          due;
  } exp_t;

  exp_t        wq[$];
  logic [31:0] aq[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (I_GNT || D_GNT) chk("gnt_excl", 64'(I_GNT & D_GNT), 0);
    if (MEM_EN) begin
      if (aq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_mem_en: got addr %h want idle", MEM_ADDR);
      end else begin
        chk("mem_addr", MEM_ADDR, aq.pop_front());
      end
    end
    if (I_VALID || D_VALID) begin
      chk("valid_excl", 64'(I_VALID & D_VALID), 0);
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid: got I=%b D=%b want none",
                 I_VALID, D_VALID);
      end else begin
        e = wq.pop_front();
        chk("valid_port", 64'(D_VALID), 64'(e.d));
        chk("valid_cycle", cyc, e.due);
        if (e.d) begin
          chk("d_rd", D_RD, e.w);
          chk("i_rd_hold", I_RD, last_i);
          last_d = e.w;
        end else begin
          chk("i_rd", I_RD, e.w);
          chk("d_rd_hold", D_RD, last_d);
          last_i = e.w;
        end
      end
    end
  end

  // Raise a request, wait for its grant, queue expectations, then drop it
  // and scribble the address to prove it is not re-sampled.
  task automatic req(input bit d, input logic [31:0] a, input logic [31:0] w,
                     input bit abort, output int g);
    int n = 0;
    if (d) begin D_REQ = 1'b1; D_ADDR = a; end
    else begin I_REQ = 1'b1; I_ADDR = a; end
    @(negedge CLK);
    while (!(d ? D_GNT : I_GNT) && n < 30) begin
      @(negedge CLK);
      n++;
    end
    g = cyc;
    chk("gnt_seen", 64'(d ? D_GNT : I_GNT), 1);
    chk("gnt_other", 64'(d ? I_GNT : D_GNT), 0);
    for (int k = 0; k < (abort ? 2 : BS); k++) aq.push_back(a + 32'(k));
    if (!abort) wq.push_back('{d, w, g + BS + 1});
    @(posedge CLK); #1;
    if (d) begin D_REQ = 1'b0; D_ADDR = 32'h40; end
    else begin I_REQ = 1'b0; I_ADDR = 32'h40; end
  endtask

  task automatic drain();
    int n = 0;
    while ((wq.size() != 0 || aq.size() != 0) && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", 64'(wq.size() + aq.size()), 0);
    @(posedge CLK); #1;
  endtask

  int g1, g2, prev;
  bit ed;
  logic [31:0] ra;
  logic [31:0] rw;

  initial begin
    RESET = 1'b1;
    I_REQ = 1'b0; I_ADDR = '0;
    D_REQ = 1'b0; D_ADDR = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_gnt", {62'd0, I_GNT, D_GNT}, 0);
    chk("rst_valid", {62'd0, I_VALID, D_VALID}, 0);
    chk("rst_i_rd", I_RD, 0);
    chk("rst_d_rd", D_RD, 0);
    chk("rst_mem_en", 64'(MEM_EN), 0);
    chk("rst_mem_addr", MEM_ADDR, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Plain I read
    req(1'b0, 32'h10, 32'hDDCCBBAA, 1'b0, g1);
    drain();

    // Address wraparound
    req(1'b0, 32'hFFFFFFFE, 32'h44332211, 1'b0, g1);
    drain();

    // D raised while I is busy; grant only once back in IDLE
    req(1'b0, 32'h10, 32'hDDCCBBAA, 1'b0, g1);
    @(posedge CLK); #1;
    req(1'b1, 32'h20, 32'h04030201, 1'b0, g2);
    chk("busy_gnt_cycle", g2, g1 + BS + 2);
    drain();

    // Reset during the second READ cycle
    req(1'b0, 32'h10, 32'hDDCCBBAA, 1'b1, g1);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    last_i = '0;
    last_d = '0;
    @(negedge CLK);
    chk("abort_mem_en", 64'(MEM_EN), 0);
    chk("abort_i_rd", I_RD, 0);
    chk("abort_d_rd", D_RD, 0);
    chk("abort_addr_q", 64'(aq.size()), 0);
    for (int k = 0; k < 6; k++) begin
      chk("abort_no_valid", 64'(I_VALID), 0);
      @(negedge CLK);
    end
    @(posedge CLK); #1;

    // Both held: round-robin (or fixed priority) from reset
    I_REQ = 1'b1; I_ADDR = 32'h10;
    D_REQ = 1'b1; D_ADDR = 32'h20;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      @(negedge CLK);
      while (!(I_GNT || D_GNT) && n < 30) begin
        @(negedge CLK);
        n++;
      end
`ifdef FIXED_PRIORITY_EN
      ed = 1'b0;
`else
      ed = k[0];
`endif
      chk("rr_any_gnt", 64'(I_GNT | D_GNT), 1);
      chk("rr_port", 64'(D_GNT), 64'(ed));
      if (k > 0) chk("rr_gap", cyc - prev, BS + 2);
      prev = cyc;
      ra = ed ? 32'h20 : 32'h10;
      rw = ed ? 32'h04030201 : 32'hDDCCBBAA;
      for (int b = 0; b < BS; b++) aq.push_back(ra + 32'(b));
      wq.push_back('{ed, rw, cyc + BS + 1});
      @(posedge CLK); #1;
    end
    I_REQ = 1'b0;
    D_REQ = 1'b0;
    drain();
    repeat (3) @(posedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
